// File: rtl/spi_req_arbiter_if.sv
// rtl/spi_req_arbiter_if.sv - link between the request arbiter and the single SPI master core
interface spi_req_arbiter_if;
  logic        spi_send;
  logic [15:0] spi_data_in;
  logic [15:0] spi_data_out;
  logic        spi_done;

  modport master (
    output spi_send,
    output spi_data_in,
    input  spi_data_out,
    input  spi_done
  );

  modport slave (
    input  spi_send,
    input  spi_data_in,
    output spi_data_out,
    output spi_done
  );
endinterface

// File: rtl/spi_req_arbiter.sv
// rtl/spi_req_arbiter.sv - round-robin arbiter sharing one 16-bit SPI master core among NREQ requesters
// Optional watchdog on the WAIT state is enabled with `define SPI_ARB_TIMEOUT_EN.
module spi_req_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic [NREQ-1:0]          req,
  input  logic [16*NREQ-1:0]       wdata,
  output logic [NREQ-1:0]          ack,
  output logic [15:0]              rdata,
  output logic                     err,
  output logic                     busy,
  output logic [$clog2(NREQ)-1:0]  owner,
  spi_req_arbiter_if.master        spi
);

  localparam int OW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("spi_req_arbiter: NREQ must be in 2..8");
  end
  if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("spi_req_arbiter: TIMEOUT must be in 2..65535");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_WAIT,
    S_ACK
  } state_t;

  state_t          state_q, state_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [15:0]     tx_q, tx_d;
  logic [15:0]     rdata_q, rdata_d;
  logic [OW-1:0]   cand;
  logic            found;

`ifdef SPI_ARB_TIMEOUT_EN
  logic [15:0]     wdog_q, wdog_d;
  logic            err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    tx_d    = tx_q;
    rdata_d = rdata_q;
    cand    = '0;
    found   = 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
    wdog_d  = wdog_q;
    err_d   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        // Search starts just past the last grantee so it drops to lowest priority.
        for (int k = 1; k <= NREQ; k++) begin
          cand = OW'((int'(owner_q) + k) % NREQ);
          if (!found && req[cand]) begin
            found   = 1'b1;
            owner_d = cand;
            tx_d    = wdata[16*cand +: 16];
          end
        end
        if (found) begin
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        state_d = S_WAIT;
`ifdef SPI_ARB_TIMEOUT_EN
        wdog_d  = '0;
`endif
      end
      S_WAIT: begin
`ifdef SPI_ARB_TIMEOUT_EN
        wdog_d = wdog_q + 16'd1;
`endif
        if (spi.spi_done) begin
          rdata_d = spi.spi_data_out;
          state_d = S_ACK;
        end
`ifdef SPI_ARB_TIMEOUT_EN
        else if (wdog_q == 16'(TIMEOUT - 1)) begin
          // A done arriving in this same cycle takes the branch above instead.
          rdata_d = 16'hFFFF;
          err_d   = 1'b1;
          state_d = S_ACK;
        end
`endif
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= S_IDLE;
      owner_q <= OW'(NREQ - 1);
      tx_q    <= '0;
      rdata_q <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      wdog_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      tx_q    <= tx_d;
      rdata_q <= rdata_d;
`ifdef SPI_ARB_TIMEOUT_EN
      wdog_q  <= wdog_d;
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    ack = '0;
    for (int i = 0; i < NREQ; i++) begin
      ack[i] = (state_q == S_ACK) && (owner_q == OW'(i));
    end
  end

  assign rdata           = rdata_q;
  assign busy            = (state_q != S_IDLE);
  assign owner           = owner_q;
  assign spi.spi_send    = (state_q == S_SEND);
  assign spi.spi_data_in = tx_q;

`ifdef SPI_ARB_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_req_arbiter.sv
// tb/tb_spi_req_arbiter.sv - directed self-checking bench for spi_req_arbiter
module tb_spi_req_arbiter;

  logic        clk = 1'b0;
  logic        nrst;
  logic [3:0]  req;
  logic [63:0] wdata;
  logic [3:0]  ack;
  logic [15:0] rdata;
  logic        err;
  logic        busy;
  logic [1:0]  owner;
  int          checks = 0;
  int          errors = 0;
  int          send_cnt = 0;
  int          send_base;

  spi_req_arbiter_if spi_if ();

  spi_req_arbiter #(.NREQ(4), .TIMEOUT(16)) dut (
    .clk   (clk),
    .nrst  (nrst),
    .req   (req),
    .wdata (wdata),
    .ack   (ack),
    .rdata (rdata),
    .err   (err),
    .busy  (busy),
    .owner (owner),
    .spi   (spi_if)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (spi_if.spi_send === 1'b1) send_cnt <= send_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    req  = 4'b0000;
    spi_if.spi_done     = 1'b0;
    spi_if.spi_data_out = 16'h0000;
    tick();
    tick();
    nrst = 1'b1;
  endtask

  task automatic serve(input int exp_owner, input logic [15:0] exp_tx,
                       input logic [15:0] rx, input int lat, input bit drop);
    int n;
    n = 0;
    while (spi_if.spi_send !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("send_seen", {31'd0, spi_if.spi_send}, 32'd1);
    chk("owner", {30'd0, owner}, exp_owner);
    chk("spi_data_in", {16'd0, spi_if.spi_data_in}, {16'd0, exp_tx});
    repeat (lat) begin
      tick();
      chk("wait_quiet", {27'd0, spi_if.spi_send, ack}, 32'd0);
    end
    spi_if.spi_done     = 1'b1;
    spi_if.spi_data_out = rx;
    tick();
    spi_if.spi_done     = 1'b0;
    chk("ack", {28'd0, ack}, 32'd1 << exp_owner);
    chk("rdata", {16'd0, rdata}, {16'd0, rx});
    chk("err_clear", {31'd0, err}, 32'd0);
    if (drop) req[exp_owner] = 1'b0;
    tick();
    chk("ack_pulse", {28'd0, ack}, 32'd0);
  endtask

  initial begin
    wdata = 64'h0;
    do_reset();
    chk("rst_ack", {28'd0, ack}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_send", {31'd0, spi_if.spi_send}, 32'd0);
    chk("rst_rdata", {16'd0, rdata}, 32'd0);
    chk("rst_data_in", {16'd0, spi_if.spi_data_in}, 32'd0);
    chk("rst_owner", {30'd0, owner}, 32'd3);

    // single transfer, 40-cycle core latency
    send_base = send_cnt;
    wdata[15:0] = 16'hA5C3;
    req = 4'b0001;
    tick();
    chk("send_latency", {31'd0, spi_if.spi_send}, 32'd1);
    chk("busy_send", {31'd0, busy}, 32'd1);
    serve(0, 16'hA5C3, 16'h1234, 39, 1'b1);
    chk("busy_after_ack", {31'd0, busy}, 32'd0);
    chk("rdata_held", {16'd0, rdata}, 32'h1234);
    chk("one_send", send_cnt - send_base, 32'd1);

    // all four requesting from reset: 0,1,2,3
    do_reset();
    send_base = send_cnt;
    wdata = 64'h4444_3333_2222_1111;
    req = 4'b1111;
    serve(0, 16'h1111, 16'hB000, 3, 1'b1);
    serve(1, 16'h2222, 16'hB001, 3, 1'b1);
    serve(2, 16'h3333, 16'hB002, 3, 1'b1);
    serve(3, 16'h4444, 16'hB003, 3, 1'b1);
    chk("four_sends", send_cnt - send_base, 32'd4);

    // after 2 served, 1 and 3 together: 3 then 1
    req = 4'b0100;
    serve(2, 16'h3333, 16'hC002, 2, 1'b1);
    req = 4'b1010;
    serve(3, 16'h4444, 16'hC003, 2, 1'b1);
    serve(1, 16'h2222, 16'hC001, 2, 1'b1);

    // requester 0 re-requests immediately while 1 waits: 0,1,0
    req = 4'b0011;
    serve(0, 16'h1111, 16'hD000, 2, 1'b0);
    serve(1, 16'h2222, 16'hD001, 2, 1'b1);
    serve(0, 16'h1111, 16'hD002, 2, 1'b1);
    chk("idle_again", {31'd0, busy}, 32'd0);

    // reset in WAIT abandons the transfer
    req = 4'b0100;
    tick();
    tick();
    chk("in_wait", {31'd0, busy}, 32'd1);
    nrst = 1'b0;
    req  = 4'b0000;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_owner", {30'd0, owner}, 32'd3);
    chk("arst_rdata", {16'd0, rdata}, 32'd0);
    chk("arst_data_in", {16'd0, spi_if.spi_data_in}, 32'd0);
    tick();
    nrst = 1'b1;
    spi_if.spi_done     = 1'b1;
    spi_if.spi_data_out = 16'hDEAD;
    tick();
    spi_if.spi_done = 1'b0;
    chk("late_done_ack", {28'd0, ack}, 32'd0);
    chk("late_done_rdata", {16'd0, rdata}, 32'd0);
    tick();
    chk("late_done_idle", {28'd0, ack, busy}, 32'd0);

    // core never answers
    wdata[15:0] = 16'h0F0F;
    req = 4'b0001;
    tick();
    chk("to_send", {31'd0, spi_if.spi_send}, 32'd1);
    tick();
    for (int k = 1; k < 16; k++) begin
      tick();
      chk("to_waiting", {27'd0, ack, err}, 32'd0);
    end
    tick();
`ifdef SPI_ARB_TIMEOUT_EN
    chk("to_ack", {28'd0, ack}, 32'd1);
    chk("to_err", {31'd0, err}, 32'd1);
    chk("to_rdata", {16'd0, rdata}, 32'hFFFF);
    req = 4'b0000;
    tick();
    chk("to_err_pulse", {30'd0, err, busy}, 32'd0);
    spi_if.spi_done     = 1'b1;
    spi_if.spi_data_out = 16'h5555;
    tick();
    spi_if.spi_done = 1'b0;
    chk("to_late_done", {28'd0, ack}, 32'd0);
    chk("to_late_rdata", {16'd0, rdata}, 32'hFFFF);
`else
    chk("nto_busy", {31'd0, busy}, 32'd1);
    chk("nto_ack", {27'd0, ack, err}, 32'd0);
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("nto_hold", {26'd0, busy, ack, err}, 32'h20);
    end
    spi_if.spi_done     = 1'b1;
    spi_if.spi_data_out = 16'h7777;
    tick();
    spi_if.spi_done = 1'b0;
    chk("nto_ack_done", {28'd0, ack}, 32'd1);
    chk("nto_rdata", {16'd0, rdata}, 32'h7777);
    req = 4'b0000;
    tick();
    chk("nto_idle", {31'd0, busy}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_req_arbiter.md
Name: spi_req_arbiter

Overview:
- Shares the single 16-bit SPI master core between NREQ independent requesters.
- Arbitrates round-robin and drives the core's send/data_in. Waits for done, then returns the core's data_out and a one-cycle ack to the winning requester.
- Sits between the per-function register blocks and the SPI master core.

Parameters:
- NREQ, 4, number of requesters; legal range 2..8.
- TIMEOUT, 1024, watchdog limit in clk cycles while waiting for spi_done; legal range 2..65535. Used only with SPI_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; everything on the rising edge.
- nrst  in  1  asynchronous active-low reset.
- req  in  NREQ  per-requester transfer request; level, held until ack.
- wdata  in  16*NREQ  TX words; requester i owns bits [16*i+15:16*i]. Stable while req[i]=1.
- ack  out  NREQ  one-cycle completion pulse to the granted requester.
- rdata  out  16  RX word of the last completed transfer; held until the next completion.
- err  out  1  one-cycle pulse together with ack when the transfer timed out.
- busy  out  1  high in every state except IDLE.
- owner  out  $clog2(NREQ)  index of the current/last grantee.
- spi_send  out  1  one-cycle start pulse to the SPI core.
- spi_data_in  out  16  TX word to the SPI core; registered, stable from SEND until the next grant.
- spi_data_out  in  16  RX word from the SPI core; valid in the spi_done cycle.
- spi_done  in  1  one-cycle completion pulse from the SPI core.

Behaviour:
- Reset (asynchronous, nrst=0): state=IDLE; ack=0, err=0, busy=0, spi_send=0; rdata=0, spi_data_in=0; owner=NREQ-1 (so req[0] has top priority first); watchdog counter=0. Reset mid-transfer abandons the transfer with no ack. The core is reset by the same nrst.
- Registered FSM: IDLE -> SEND -> WAIT -> ACK -> IDLE.
- IDLE:
  - If any req bit is set, grant the first set index found searching owner+1, owner+2, ... modulo NREQ.
  - Load owner with that index, load spi_data_in with its wdata slice, go to SEND.
  - No req: stay. spi_done seen in IDLE is ignored.
- SEND: spi_send=1 for exactly this cycle; go to WAIT. Latency is req sampled at edge t, spi_send high in cycle t+1.
- WAIT:
  - On spi_done=1: register spi_data_out into rdata, go to ACK.
  - spi_done arriving in the same cycle as SEND is not possible by the core contract and is not handled.
- ACK:
  - ack[owner]=1 for one cycle; rdata is already valid in this cycle; go to IDLE.
  - The requester drops req on the edge ending the ack cycle.
  - If req[owner] is still high in IDLE, it is a new request. It competes normally and sits at lowest priority because the pointer has advanced.
- req bits deasserted before ack are illegal; the started transfer still completes and acks.
- Requests arriving during SEND/WAIT/ACK are held by the requester and arbitrated in the next IDLE cycle.
- At most one ack bit is high at any time. spi_send never re-asserts before ack.

Optional Feature:
- Macro: SPI_ARB_TIMEOUT_EN.
- Defined:
  - The watchdog counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT without spi_done: rdata=16'hFFFF, go to ACK, assert err together with ack[owner].
  - spi_done in the same cycle as the timeout wins: normal completion, no err.
  - A late spi_done arriving after the timeout is ignored.
- Not defined: no counter logic; WAIT waits indefinitely; err tied to 0.

Test Plan:
- req=4'b0001, wdata0=16'hA5C3; core returns done after 40 cycles with data_out=16'h1234 -> exactly one spi_send pulse one cycle after req; spi_data_in=16'hA5C3; ack=4'b0001 one cycle after done; rdata=16'h1234; busy=0 the cycle after ack.
- req=4'b1111 held, each requester drops on its ack -> grant order 0,1,2,3; owner=0,1,2,3; four spi_send pulses; no overlapping ack.
- After requester 2 is served, req[1] and req[3] rise together -> 3 is granted first, then 1.
- Requester 0 keeps req=1 after ack while req[1]=1 -> 1 is granted next, then 0 again.
- Assert nrst=0 during WAIT, then release, then inject spi_done -> no ack; outputs at reset values; FSM stays in IDLE.
- With SPI_ARB_TIMEOUT_EN and TIMEOUT=16, core never sends done -> ack and err pulse together 16 cycles after entering WAIT; rdata=16'hFFFF. Without the macro, busy stays 1 and err never asserts.
